seq_branch_predictor: RTL
=========================

Name: seq_branch_predictor

Overview:
- Fetch-side counterpart of the combinational jump/branch resolver: predicts the next fetch address, and learns from the resolver's outcome in EX.
- Direct-mapped branch target buffer; each entry holds valid, tag, target and a 2-bit saturating counter.
- Also flags mispredictions, supplies the corrected PC, and keeps statistics counters.
- All addresses are instruction-memory word addresses; sequential next address is pc+1.

Parameters:
- ADDR_BIT, 10, instruction word-address width (matches `IM_ADDR_BIT).
- ENTRY_BIT, 4, log2 of entry count; index = pc[ENTRY_BIT-1:0], tag = pc[ADDR_BIT-1:ENTRY_BIT].

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- pc_f  in  ADDR_BIT  fetch-stage PC.
- pred_taken  out  1  prediction is taken.
- pred_pc  out  ADDR_BIT  predicted next PC.
- upd_en  in  1  resolved instruction valid this cycle.
- upd_pc  in  ADDR_BIT  PC of the resolved instruction.
- upd_is_branch  in  1  resolver is_branch.
- upd_branched  in  1  resolver branched.
- upd_jumped  in  1  resolver jumped.
- upd_target  in  ADDR_BIT  resolver pc_new.
- upd_pred_pc  in  ADDR_BIT  pred_pc carried down the pipeline with this instruction.
- mispredict  out  1  redirect required.
- fix_pc  out  ADDR_BIT  correct next PC.
- clr  in  1  start table invalidation sweep.
- busy  out  1  sweep in progress.
- stat_ctrl_cnt  out  32  resolved control-flow instructions.
- stat_miss_cnt  out  32  mispredicts.

Behaviour:
- Reset (rst_n low, async):
  - All valid bits, counters, tags and targets clear to 0.
  - FSM goes to IDLE; busy=0; stats=0.
  - Consequently pred_taken=0 and pred_pc=pc_f+1.
- Lookup (combinational from registered table):
  - hit = valid[idx] && tag matches.
  - pred_taken = hit && ctr[1] && state==IDLE.
  - pred_pc = pred_taken ? target[idx] : pc_f+1, with +1 wrapping modulo 2^ADDR_BIT.
  - No write-to-read bypass: a same-cycle update to the same index is visible to lookup in the next cycle only.
- Resolution (combinational):
  - taken_act = upd_jumped | upd_branched.
  - fix_pc = taken_act ? upd_target : upd_pc+1 (wrapping).
  - mispredict = upd_en && (fix_pc != upd_pred_pc).
  - mispredict is valid regardless of FSM state.
- Table update (registered; only when upd_en && state==IDLE):
  - Jump, hit or miss: write valid=1, tag, target=upd_target, ctr=11.
  - Branch hit: ctr saturating +1 if branched, else saturating -1 (floor 00, ceiling 11); target=upd_target if branched.
  - Branch miss, branched: allocate with valid=1, tag, target, ctr=10 (weak taken). Overwrites any aliasing entry.
  - Branch miss, not branched: no write.
  - Non-control (!upd_is_branch && !upd_jumped) with a tag hit: clear valid (removes an alias).
- Stats:
  - stat_ctrl_cnt += 1 when upd_en && (upd_is_branch | upd_jumped).
  - stat_miss_cnt += 1 when mispredict.
  - Both wrap at 2^32 and update in all FSM states; clr does not reset them.
- Sweep FSM, states IDLE and CLEAR:
  - IDLE: clr=1 moves to CLEAR with ptr=0.
  - CLEAR: busy=1; each cycle clears valid[ptr] and increments ptr. After clearing entry 2^ENTRY_BIT-1, returns to IDLE. The sweep takes exactly 2^ENTRY_BIT cycles.
  - clr asserted during CLEAR is ignored; the sweep is not restarted.
  - During CLEAR, all table updates are dropped and predictions are not-taken.
  - Reset mid-sweep aborts to IDLE with the table cleared.

Test Plan:
- Reset, then pc_f=0x005 -> pred_taken=0, pred_pc=0x006; busy=0; both stats 0.
- Taken branch at upd_pc=0x023, target 0x010, upd_pred_pc=0x024 -> mispredict=1, fix_pc=0x010, stat_miss_cnt=1. Next cycle pc_f=0x023 -> pred_taken=1, pred_pc=0x010.
- Counter hysteresis on the same branch, outcomes T,T,NT,NT,NT starting at ctr=10 -> counter 11,11,10,01,00. Lookup after each update -> taken,taken,taken,not,not.
- Alias: entry for 0x003 is valid and taken; non-control upd_pc=0x003 with upd_pred_pc=0x00A -> mispredict=1, fix_pc=0x004, entry invalidated. Branch 0x013 (same index) then replaces tag.
- Same-cycle update/lookup to an identical index -> old prediction this cycle, new one next cycle. pc_f=0x3FF not-taken -> pred_pc=0x000 (wrap).
- clr pulse with 16 entries -> busy high exactly 16 cycles. An upd_en issued during the sweep: no table change, but stats still count. After the sweep, all lookups are not-taken.

Source files
------------

// File: rtl/seq_branch_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with 2-bit saturating counters,
// misprediction detection against the EX-stage resolver, and an invalidation sweep.
module seq_branch_predictor #(
  parameter int unsigned ADDR_BIT  = 10,
  parameter int unsigned ENTRY_BIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_BIT-1:0] pc_f,
  output logic                pred_taken,
  output logic [ADDR_BIT-1:0] pred_pc,
  input  logic                upd_en,
  input  logic [ADDR_BIT-1:0] upd_pc,
  input  logic                upd_is_branch,
  input  logic                upd_branched,
  input  logic                upd_jumped,
  input  logic [ADDR_BIT-1:0] upd_target,
  input  logic [ADDR_BIT-1:0] upd_pred_pc,
  output logic                mispredict,
  output logic [ADDR_BIT-1:0] fix_pc,
  input  logic                clr,
  output logic                busy,
  output logic [31:0]         stat_ctrl_cnt,
  output logic [31:0]         stat_miss_cnt
);

  localparam int unsigned ENTRIES = 2 ** ENTRY_BIT;
  localparam int unsigned TAG_BIT = ADDR_BIT - ENTRY_BIT;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t               state, state_next;
  logic [ENTRY_BIT-1:0] ptr, ptr_next;

  logic                valid  [ENTRIES];
  logic [TAG_BIT-1:0]  tag    [ENTRIES];
  logic [ADDR_BIT-1:0] target [ENTRIES];
  logic [1:0]          ctr    [ENTRIES];

  logic [ENTRY_BIT-1:0] idx, uidx;
  logic [TAG_BIT-1:0]   utag;
  logic                 hit, upd_hit, taken_act;
  logic [1:0]           ctr_inc, ctr_dec;

  // Lookup reads only registered table state: no same-cycle bypass from updates.
  always_comb begin
    idx        = pc_f[ENTRY_BIT-1:0];
    hit        = valid[idx] && (tag[idx] == pc_f[ADDR_BIT-1:ENTRY_BIT]);
    pred_taken = hit && ctr[idx][1] && (state == IDLE);
    pred_pc    = pred_taken ? target[idx] : pc_f + ADDR_BIT'(1);
  end

  always_comb begin
    taken_act  = upd_jumped | upd_branched;
    fix_pc     = taken_act ? upd_target : upd_pc + ADDR_BIT'(1);
    mispredict = upd_en && (fix_pc != upd_pred_pc);
  end

  always_comb begin
    uidx    = upd_pc[ENTRY_BIT-1:0];
    utag    = upd_pc[ADDR_BIT-1:ENTRY_BIT];
    upd_hit = valid[uidx] && (tag[uidx] == utag);
    ctr_inc = (ctr[uidx] == 2'b11) ? 2'b11 : ctr[uidx] + 2'b01;
    ctr_dec = (ctr[uidx] == 2'b00) ? 2'b00 : ctr[uidx] - 2'b01;
  end

  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    unique case (state)
      IDLE: begin
        if (clr) begin
          state_next = CLEAR;
          ptr_next   = '0;
        end
      end
      CLEAR: begin
        ptr_next = ptr + ENTRY_BIT'(1);
        if (ptr == '1) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state == CLEAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        valid[i]  <= 1'b0;
        tag[i]    <= '0;
        target[i] <= '0;
        ctr[i]    <= '0;
      end
    end else if (state == CLEAR) begin
      valid[ptr] <= 1'b0;
    end else if (upd_en) begin
      if (upd_jumped) begin
        valid[uidx]  <= 1'b1;
        tag[uidx]    <= utag;
        target[uidx] <= upd_target;
        ctr[uidx]    <= 2'b11;
      end else if (upd_is_branch) begin
        if (upd_hit) begin
          if (upd_branched) begin
            ctr[uidx]    <= ctr_inc;
            target[uidx] <= upd_target;
          end else begin
            ctr[uidx] <= ctr_dec;
          end
        end else if (upd_branched) begin
          valid[uidx]  <= 1'b1;
          tag[uidx]    <= utag;
          target[uidx] <= upd_target;
          ctr[uidx]    <= 2'b10;
        end
      end else if (upd_hit) begin
        // A non-control instruction hitting the table means the entry is an alias.
        valid[uidx] <= 1'b0;
      end
    end
  end

  // Statistics keep counting through a sweep and are only cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ctrl_cnt <= '0;
      stat_miss_cnt <= '0;
    end else begin
      if (upd_en && (upd_is_branch || upd_jumped)) stat_ctrl_cnt <= stat_ctrl_cnt + 32'd1;
      if (mispredict) stat_miss_cnt <= stat_miss_cnt + 32'd1;
    end
  end

endmodule
